// File: rtl/alu_b_src_mux_if.sv
//------------------------------------------------------------------------------
// Module      : alu_b_src_mux_if
// Description : Operand-B select bus: source operands and controls in, selected
//               operand, flags and selection counters out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_b_src_mux_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic signed [WIDTH-1:0] ru_rs2;
    logic signed [WIDTH-1:0] Imm_ext;
    logic                    sel;
    logic                    en;
    logic                    clr_cnt;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] b_q;
    logic                    b_zero;
    logic                    b_neg;
    logic        [CNT_W-1:0] rs2_cnt;
    logic        [CNT_W-1:0] imm_cnt;

    modport master (
        output ru_rs2, Imm_ext, sel, en, clr_cnt,
        input  b, b_q, b_zero, b_neg, rs2_cnt, imm_cnt
    );

    modport slave (
        input  ru_rs2, Imm_ext, sel, en, clr_cnt,
        output b, b_q, b_zero, b_neg, rs2_cnt, imm_cnt
    );
endinterface

`default_nettype wire

// File: rtl/alu_b_src_mux.sv
//------------------------------------------------------------------------------
// Module      : alu_b_src_mux
// Description : ALU operand-B select (rs2 vs immediate) with registered copy,
//               sign/zero flags and saturating per-source selection counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_b_src_mux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    alu_b_src_mux_if.slave bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic signed [WIDTH-1:0] w_b;
    logic        [1:0]       w_inc;
    logic signed [WIDTH-1:0] r_b_q;

    // Plain ternary: an unknown sel propagates X rather than picking a source.
    assign w_b      = bus.sel ? bus.Imm_ext : bus.ru_rs2;

    assign bus.b      = w_b;
    assign bus.b_zero = (w_b == '0);
    assign bus.b_neg  = w_b[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_q <= '0;
        end else if (bus.en) begin
            r_b_q <= w_b;
        end
    end

    assign bus.b_q = r_b_q;

    // Index 0 counts rs2 selections, index 1 counts immediate selections.
    assign w_inc[0] = bus.en & ~bus.sel;
    assign w_inc[1] = bus.en &  bus.sel;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (bus.clr_cnt) begin
                r_cnt <= '0;
            end else if (w_inc[gi] && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.rs2_cnt = g_cnt[0].r_cnt;
    assign bus.imm_cnt = g_cnt[1].r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_b_src_mux.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_b_src_mux
// Description : Self-checking bench for alu_b_src_mux (16-bit and 2-bit counters).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_b_src_mux;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 2;
    localparam longint C_MAX   = (64'd1 << CNT_W) - 1;
    localparam longint C_MAX_S = (64'd1 << CNT_W_S) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_b_src_mux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W))   bus   ();
    alu_b_src_mux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W_S)) bus_s ();

    assign bus_s.ru_rs2  = bus.ru_rs2;
    assign bus_s.Imm_ext = bus.Imm_ext;
    assign bus_s.sel     = bus.sel;
    assign bus_s.en      = bus.en;
    assign bus_s.clr_cnt = bus.clr_cnt;

    alu_b_src_mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu_b_src_mux #(.WIDTH(WIDTH), .CNT_W(CNT_W_S)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: counters kept as unbounded integers clipped at max.
    logic [WIDTH-1:0] m_bq;
    longint           m_rs2, m_imm, s_rs2, s_imm;

    function automatic void model_reset();
        m_bq  = '0;
        m_rs2 = 0;
        m_imm = 0;
        s_rs2 = 0;
        s_imm = 0;
    endfunction

    function automatic void model_edge();
        logic [WIDTH-1:0] chosen;
        chosen = (bus.sel == 1'b1) ? bus.Imm_ext : bus.ru_rs2;
        if (bus.en) m_bq = chosen;
        if (bus.clr_cnt) begin
            m_rs2 = 0; m_imm = 0; s_rs2 = 0; s_imm = 0;
        end else if (bus.en) begin
            if (bus.sel) begin
                m_imm = (m_imm + 1 > C_MAX)   ? C_MAX   : m_imm + 1;
                s_imm = (s_imm + 1 > C_MAX_S) ? C_MAX_S : s_imm + 1;
            end else begin
                m_rs2 = (m_rs2 + 1 > C_MAX)   ? C_MAX   : m_rs2 + 1;
                s_rs2 = (s_rs2 + 1 > C_MAX_S) ? C_MAX_S : s_rs2 + 1;
            end
        end
    endfunction

    task automatic drive(input logic s, input logic e, input logic c,
                         input logic [WIDTH-1:0] rs2, input logic [WIDTH-1:0] imm);
        bus.sel     = s;
        bus.en      = e;
        bus.clr_cnt = c;
        bus.ru_rs2  = rs2;
        bus.Imm_ext = imm;
    endtask

    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0064);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.b_q !== '0 || bus.rs2_cnt !== '0 || bus.imm_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: b_q=%h rs2_cnt=%0d imm_cnt=%0d, want all 0",
                     bus.b_q, bus.rs2_cnt, bus.imm_cnt);
        end
        vectors++;
        if (bus.b !== 32'h0000_0064) begin
            miscompares++;
            $display("FAIL b_during_reset: got %h want 00000064", bus.b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_edge_and_hold();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0064);
        step();
        vectors++;
        if (bus.b_q !== 32'h0000_0064 || bus.imm_cnt !== 16'd1 || bus.rs2_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL first_edge: b_q=%h imm_cnt=%0d rs2_cnt=%0d, want 00000064/1/0",
                     bus.b_q, bus.imm_cnt, bus.rs2_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000);
        step();
        vectors++;
        if (bus.b_q !== 32'h0000_0064 || bus.imm_cnt !== 16'd1 || bus.rs2_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL en0_hold: b_q=%h imm_cnt=%0d rs2_cnt=%0d, want 00000064/1/0",
                     bus.b_q, bus.imm_cnt, bus.rs2_cnt);
        end
    endtask

    typedef struct {
        logic             s;
        logic [WIDTH-1:0] rs2;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_b;
        logic             exp_z;
        logic             exp_n;
    } dir_vec_t;

    task automatic test_mux_directed();
        dir_vec_t tbl[7];
        tbl[0] = '{1'b0, 32'h0000_0014, 32'h0000_0064, 32'h0000_0014, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0014, 32'h0000_0064, 32'h0000_0064, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'hFFFF_FFE0, 32'h0000_0064, 32'hFFFF_FFE0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0064, 32'h7FFF_FFFF, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_0ABC, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        foreach (tbl[i]) begin
            drive(tbl[i].s, 1'b0, 1'b0, tbl[i].rs2, tbl[i].imm);
            #1;
            vectors++;
            if (bus.b !== tbl[i].exp_b || bus.b_zero !== tbl[i].exp_z || bus.b_neg !== tbl[i].exp_n) begin
                miscompares++;
                $display("FAIL mux_dir[%0d]: b=%h z=%b n=%b, want b=%h z=%b n=%b", i,
                         bus.b, bus.b_zero, bus.b_neg, tbl[i].exp_b, tbl[i].exp_z, tbl[i].exp_n);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0FFF);
        #1;
        vectors++;
        if (bus.b !== 32'h0000_0FFF) begin
            miscompares++;
            $display("FAIL mux_imm12: got %h want 00000FFF", bus.b);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0);
        repeat (5) step();
        vectors++;
        if (bus_s.rs2_cnt !== 2'd3 || bus_s.imm_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL sat_small: rs2_cnt=%0d imm_cnt=%0d, want 3/0", bus_s.rs2_cnt, bus_s.imm_cnt);
        end
        vectors++;
        if (bus.rs2_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL count_wide: rs2_cnt=%0d want 5", bus.rs2_cnt);
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 32'h0);
        step();
        vectors++;
        if (bus.rs2_cnt !== '0 || bus.imm_cnt !== '0 || bus_s.rs2_cnt !== '0) begin
            miscompares++;
            $display("FAIL clr_priority: rs2_cnt=%0d imm_cnt=%0d small=%0d, want 0",
                     bus.rs2_cnt, bus.imm_cnt, bus_s.rs2_cnt);
        end
        vectors++;
        if (bus.b_q !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL clr_keeps_bq: b_q=%h want cafe0001", bus.b_q);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [WIDTH-1:0] rs2, imm, exp_b;
            rs2 = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            imm = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            drive(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), rs2, imm);
            #1;
            exp_b = bus.sel ? imm : rs2;
            vectors++;
            if (bus.b !== exp_b || bus.b_zero !== (exp_b == 0) || bus.b_neg !== ($signed(exp_b) < 0)) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: b=%h z=%b n=%b, want %h", n,
                         bus.b, bus.b_zero, bus.b_neg, exp_b);
            end
            step();
            vectors++;
            if (bus.b_q !== m_bq || bus.rs2_cnt !== CNT_W'(m_rs2) || bus.imm_cnt !== CNT_W'(m_imm)
                || bus_s.rs2_cnt !== CNT_W_S'(s_rs2) || bus_s.imm_cnt !== CNT_W_S'(s_imm)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: b_q=%h cnt=%0d/%0d small=%0d/%0d, want %h %0d/%0d %0d/%0d",
                         n, bus.b_q, bus.rs2_cnt, bus.imm_cnt, bus_s.rs2_cnt, bus_s.imm_cnt,
                         m_bq, m_rs2, m_imm, s_rs2, s_imm);
            end
        end
    endtask

    task automatic test_async_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0777);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (bus.b_q !== '0 || bus.rs2_cnt !== '0 || bus.imm_cnt !== '0 || bus_s.imm_cnt !== '0) begin
            miscompares++;
            $display("FAIL async_reset: b_q=%h cnt=%0d/%0d small_imm=%0d, want 0",
                     bus.b_q, bus.rs2_cnt, bus.imm_cnt, bus_s.imm_cnt);
        end
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'h0000_0777);
        step();
        vectors++;
        if (bus.b_q !== 32'h0000_0042 || bus.rs2_cnt !== 16'd1 || bus.imm_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL post_reset_edge: b_q=%h cnt=%0d/%0d, want 00000042 1/0",
                     bus.b_q, bus.rs2_cnt, bus.imm_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_edge_and_hold();
        test_mux_directed();
        test_saturation();
        test_clear_priority();
        test_random();
        test_async_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
